// File: rtl/key_pkg.sv
// Shared types and constants for the push-button debouncer.
// State encoding is fixed so it stays readable in waveforms and netlists.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int unsigned SYNC_STAGES = 2;

    // Raw pin level seen when the button is not pressed.
    function automatic logic inactive_raw(input bit active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-flop synchroniser, debounce FSM with qualification counter,
// registered level and single-cycle press/release strobes.
module key_debounce_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          IDLE_RAW = inactive_raw(KEY_ACTIVE_LOW);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    key_state_t             state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic                   level_nx, press_nx, rel_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= {SYNC_STAGES{IDLE_RAW}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], key_raw};
        end
    end

    assign s = sync[SYNC_STAGES-1] ^ KEY_ACTIVE_LOW;

    // Outputs are registered alongside the state so strobes last exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            key_level   <= level_nx;
            key_press   <= press_nx;
            key_release <= rel_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (s) begin
                    state_nx = PRESS_WAIT;
                    cnt_nx   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = PRESSED;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_nx = RELEASE_WAIT;
                    cnt_nx   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        press_nx = (state == PRESS_WAIT) && s && (cnt == CNT_LAST);
        rel_nx   = (state == RELEASE_WAIT) && !s && (cnt == CNT_LAST);
        level_nx = (state_nx == PRESSED) || (state_nx == RELEASE_WAIT);
    end

endmodule

// File: rtl/key_debouncer.sv
// Board push-button front end: NUM_KEYS fully independent debounce channels.
// Produces clean levels plus press/release strobes in the clk domain.
module key_debouncer
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .key_raw    (key_raw[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i])
        );
    end

endmodule
